// File: rtl/psum_accum_ctrl.sv
// Partial-sum accumulation controller: drives an external lane adder and
// reduces a job of cfg_len vectors into one held result.
module psum_accum_ctrl #(
  parameter int N_STACK = 4,
  parameter int DW_DATA = 32,
  parameter int DW_CNT  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [DW_CNT-1:0]          cfg_len,
  input  logic                       abort,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_STACK*DW_DATA-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_STACK*DW_DATA-1:0] out_data,
  output logic [N_STACK*DW_DATA-1:0] add_a,
  output logic [N_STACK*DW_DATA-1:0] add_b,
  input  logic [N_STACK*DW_DATA-1:0] add_sum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [N_STACK*DW_DATA-1:0] r_acc;
  logic [DW_CNT-1:0]          r_cnt;
  logic [DW_CNT-1:0]          r_len;

  logic              w_start;
  logic              w_in_hs;
  logic              w_last;
  logic [DW_CNT-1:0] w_len_m1;

  // abort outranks a start in the same cycle
  assign w_start  = (r_state == S_IDLE) & start & ~abort;
  assign w_in_hs  = (r_state == S_ACCUM) & in_valid;
  assign w_len_m1 = r_len - DW_CNT'(1);
  assign w_last   = w_in_hs & (r_cnt == w_len_m1);

  assign add_a    = r_acc;
  assign add_b    = in_data;
  assign out_data = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            w_next = (cfg_len == '0) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_last) begin
            w_next = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            w_next = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_ACCUM: begin
        busy     = 1'b1;
        in_ready = 1'b1;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // acc survives the output handshake; only start or abort clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= '0;
    end else if (abort) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_start) begin
      r_len <= cfg_len;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_in_hs) begin
      r_acc <= add_sum;
      r_cnt <= r_cnt + DW_CNT'(1);
    end
  end

endmodule

// File: doc/psum_accum_ctrl.md
Name: psum_accum_ctrl

Overview:
- Sequences one external stacked-lane adder (N_STACK independent DW_DATA-bit lanes, purely combinational, a+b per lane) to reduce a stream of partial-sum vectors into one result vector.
- Owns the accumulator register and the adder operand muxing.
- Sits between the PE-array partial-sum output stream and the result writeback path.
- Accumulation length is set per job by cfg_len.

Parameters:
- N_STACK, 4, number of lanes per vector.
- DW_DATA, 32, bits per lane.
- DW_CNT, 8, width of the job-length and vector counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  job start pulse; sampled only in IDLE.
- cfg_len  input  DW_CNT  number of vectors in the job; latched when start is accepted.
- abort  input  1  synchronous job cancel.
- busy  output  1  high in any state other than IDLE.
- in_valid  input  1  partial-sum vector valid.
- in_ready  output  1  controller accepts a vector.
- in_data  input  N_STACK*DW_DATA  partial-sum vector; lane i is bits [i*DW_DATA +: DW_DATA].
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  N_STACK*DW_DATA  accumulated result.
- add_a  output  N_STACK*DW_DATA  adder operand A; driven from the accumulator register.
- add_b  output  N_STACK*DW_DATA  adder operand B; driven from in_data.
- add_sum  input  N_STACK*DW_DATA  adder result; combinational, same cycle as add_a/add_b.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, acc=0, cnt=0, len=0. Outputs: busy=0, in_ready=0, out_valid=0, out_data=0.
- out_data always equals acc. add_a=acc and add_b=in_data continuously.
- States:
  - IDLE:
    - busy=0, in_ready=0, out_valid=0.
    - start=1: len<=cfg_len, acc<=0, cnt<=0.
    - If cfg_len==0, go to DONE (result is all zeros). Otherwise go to ACCUM.
  - ACCUM:
    - in_ready=1.
    - On a handshake (in_valid & in_ready): acc<=add_sum and cnt<=cnt+1.
    - If cnt==len-1 at that handshake, go to DONE.
    - No handshake: hold all state.
  - DONE:
    - in_ready=0, out_valid=1.
    - out_valid & out_ready: go to IDLE. acc keeps the result until the next start.
    - Result is held stable while out_ready=0.
- Throughput and latency:
  - One vector per cycle while in_valid stays high.
  - out_valid rises the cycle after the last input handshake.
  - Earliest next start is the cycle after the output handshake. There is no overlap between jobs.
- Arithmetic:
  - Each lane wraps modulo 2^DW_DATA.
  - No saturation, no carry between lanes; both are the adder's property.
  - The controller does not inspect add_sum.
- cnt never exceeds len-1 in ACCUM. Maximum job length is 2^DW_CNT-1.
- start while busy=1 is ignored, including any cfg_len change.
- abort=1 in any state: next state IDLE, cnt<=0, acc<=0, out_valid deasserts next cycle. This applies even if the same cycle has an in_valid handshake or out_ready.
- abort=1 together with start in IDLE: abort wins and the job does not start.
- rst_n asserted mid-job: immediate return to reset values. The partial result is discarded.

Test Plan:
1. N_STACK=4, DW_DATA=32, cfg_len=3, start; send vectors lanes {1,2,3,4}, {10,20,30,40}, {100,200,300,400} back-to-back with out_ready=1 → out_valid for exactly 1 cycle, one cycle after the 3rd handshake, out_data lanes {111,222,333,444}; busy falls the following cycle.
2. cfg_len=2; send lane0 values 0xFFFFFFFF then 0x00000002, other lanes 0 → lane0=0x00000001, lanes1-3=0. Confirms wrap with no carry into lane1.
3. cfg_len=2; in_valid toggled 1,0,0,1; out_ready held 0 for 5 cycles → accepts exactly 2 vectors; in_ready=0 in DONE; out_valid and out_data stable all 5 cycles; IDLE one cycle after out_ready=1.
4. cfg_len=0, start → DONE the next cycle, out_data all zeros, no input handshakes. A start pulse with cfg_len=5 issued during DONE is ignored.
5. cfg_len=4; abort after 2 handshakes, with in_valid still high → state IDLE next cycle, acc=0, out_valid never asserted. A new cfg_len=1 job then returns exactly the single input vector.
6. rst_n pulsed low asynchronously between clock edges in ACCUM → busy, in_ready, out_valid and out_data go to 0 immediately and stay 0 until a new start.
